// File: rtl/xrisc_pkg.sv
// Shared types for the load/store unit: FSM states, store-buffer entry layout
// and the byte-offset width that is stripped from word addresses.
package xrisc_pkg;

  localparam int unsigned WORD_OFFSET_BITS = 2;
  localparam int unsigned XLEN             = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ST_REQ  = 2'd1,
    LD_REQ  = 2'd2,
    LD_WAIT = 2'd3
  } lsu_state_t;

  typedef struct packed {
    logic [XLEN-WORD_OFFSET_BITS-1:0] waddr;
    logic [XLEN-1:0]                  data;
  } st_entry_t;

endpackage

// File: rtl/lsu_write_buffer_if.sv
// Core-side request/response and memory-side req/gnt/rvalid signals of the LSU.
// master = core + memory environment, slave = the LSU itself.
interface lsu_write_buffer_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          req_valid;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          req_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/sync_fifo.sv
// Store FIFO: power-of-two depth, push refused when full, pop refused when
// empty. All slots plus the read pointer are exported so the owner can search
// entries in age order.
module sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_push,
  input  logic [WIDTH-1:0]                i_push_data,
  input  logic                            i_pop,
  output logic                            o_full,
  output logic                            o_empty,
  output logic [$clog2(DEPTH):0]          o_count,
  output logic [$clog2(DEPTH)-1:0]        o_rd_ptr,
  output logic [DEPTH-1:0][WIDTH-1:0]     o_entries
);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW-1:0]                r_rd_ptr;
  logic [PW-1:0]                r_wr_ptr;
  logic [PW:0]                  r_count;
  logic [DEPTH-1:0][WIDTH-1:0]  r_mem;
  logic                         w_push;
  logic                         w_pop;

  assign o_full    = (r_count == (PW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_push    = i_push & ~o_full;
  assign w_pop     = i_pop & ~o_empty;
  assign o_count   = r_count;
  assign o_rd_ptr  = r_rd_ptr;
  assign o_entries = r_mem;

  // Pointer/count bookkeeping and slot writes; pointers wrap naturally.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_mem    <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/lsu_write_buffer.sv
// Load/store unit with a store buffer. Stores are queued and drained in the
// background; loads forward from the youngest matching buffered store, and
// loads that miss the buffer overtake pending stores to memory (safe because
// no buffered store aliases the missing word).
module lsu_write_buffer
  import xrisc_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 32
) (
  input  logic               clk,
  input  logic               reset,
  lsu_write_buffer_if.slave  bus,
  output logic               buf_empty
);
  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned WAW = AW - WORD_OFFSET_BITS;
  localparam int unsigned EW  = WAW + DW;

  lsu_state_t                r_state;
  logic                      r_mem_req;
  logic                      r_mem_we;
  logic [AW-1:0]             r_mem_addr;
  logic [DW-1:0]             r_mem_wdata;
  logic                      r_rsp_valid;
  logic [DW-1:0]             r_rsp_rdata;

  logic [WAW-1:0]            w_waddr;
  logic                      w_unused_lsb;
  logic                      w_full;
  logic                      w_empty;
  logic [PW:0]               w_count;
  logic [PW-1:0]             w_rd_ptr;
  logic [DEPTH-1:0][EW-1:0]  w_entries;
  logic [EW-1:0]             w_head;
  logic [EW-1:0]             w_next;
  logic                      w_hit;
  logic [DW-1:0]             w_fwd_data;
  logic                      w_ready;
  logic                      w_acc;
  logic                      w_st_acc;
  logic                      w_ld_hit;
  logic                      w_ld_miss;
  logic                      w_miss_pending;
  logic                      w_pop;

  assign w_waddr      = bus.req_addr[AW-1:WORD_OFFSET_BITS];
  assign w_unused_lsb = ^bus.req_addr[WORD_OFFSET_BITS-1:0];

  assign w_head = w_entries[w_rd_ptr];
  assign w_next = w_entries[w_rd_ptr + PW'(1)];
  assign w_pop  = (r_state == ST_REQ) & bus.mem_gnt;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .i_clk       (clk),
    .i_rst_n     (reset),
    .i_push      (w_st_acc),
    .i_push_data ({w_waddr, bus.req_wdata}),
    .i_pop       (w_pop),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count),
    .o_rd_ptr    (w_rd_ptr),
    .o_entries   (w_entries)
  );

  // Forwarding search in age order (oldest first) so the youngest match wins.
  always_comb begin
    w_hit      = 1'b0;
    w_fwd_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (((PW+1)'(i) < w_count) &&
          (w_entries[w_rd_ptr + PW'(i)][EW-1:DW] == w_waddr)) begin
        w_hit      = 1'b1;
        w_fwd_data = w_entries[w_rd_ptr + PW'(i)][DW-1:0];
      end
    end
  end

  // Acceptance: stores need space, hits avoid the load path, misses need IDLE.
  always_comb begin
    if (bus.req_we) begin
      w_ready = ~w_full;
    end else if (w_hit) begin
      w_ready = (r_state != LD_REQ) && (r_state != LD_WAIT);
    end else begin
      w_ready = (r_state == IDLE);
    end
  end

  assign w_acc          = bus.req_valid & w_ready;
  assign w_st_acc       = w_acc & bus.req_we;
  assign w_ld_hit       = w_acc & ~bus.req_we & w_hit;
  assign w_ld_miss      = w_acc & ~bus.req_we & ~w_hit;
  assign w_miss_pending = bus.req_valid & ~bus.req_we & ~w_hit;

  // Memory-port FSM with registered request and response outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      if (w_ld_hit) begin
        r_rsp_valid <= 1'b1;
        r_rsp_rdata <= w_fwd_data;
      end
      case (r_state)
        IDLE: begin
          if (w_ld_miss) begin
            r_state    <= LD_REQ;
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= {w_waddr, {WORD_OFFSET_BITS{1'b0}}};
          end else if (!w_empty) begin
            r_state     <= ST_REQ;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= {w_head[EW-1:DW], {WORD_OFFSET_BITS{1'b0}}};
            r_mem_wdata <= w_head[DW-1:0];
          end
        end
        ST_REQ: begin
          if (bus.mem_gnt) begin
            // Chain straight into the next entry unless a miss is waiting
            // for IDLE to claim the port.
            if ((w_count > (PW+1)'(1)) && !w_miss_pending) begin
              r_mem_addr  <= {w_next[EW-1:DW], {WORD_OFFSET_BITS{1'b0}}};
              r_mem_wdata <= w_next[DW-1:0];
            end else begin
              r_state   <= IDLE;
              r_mem_req <= 1'b0;
            end
          end
        end
        LD_REQ: begin
          if (bus.mem_gnt) begin
            r_state   <= LD_WAIT;
            r_mem_req <= 1'b0;
          end
        end
        LD_WAIT: begin
          if (bus.mem_rvalid) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= bus.mem_rdata;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign buf_empty     = w_empty && (r_state != ST_REQ);

endmodule

// File: tb/tb_lsu_write_buffer.sv
// Scoreboard bench for lsu_write_buffer. The reference model is an
// architectural memory image (updated at store acceptance) plus a physical
// memory image (updated when stores reach the memory port).
module tb_lsu_write_buffer;
  import xrisc_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;

  logic clk = 1'b0;
  logic reset;
  logic buf_empty;

  lsu_write_buffer_if #(.AW(AW), .DW(DW)) bus();

  lsu_write_buffer #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .buf_empty (buf_empty)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] arch [logic [29:0]];
  logic [31:0] phys [logic [29:0]];
  st_entry_t   exp_wr [$];
  logic [31:0] exp_rsp [$];
  logic [32:0] mem_log [$];

  int          gnt_mode = 2;   // 0 random, 1 always grant, 2 never grant
  int          lat_cfg  = -1;  // read latency, -1 random
  bit          rd_busy  = 1'b0;
  int          rd_wait  = 0;
  logic [31:0] rd_addr  = '0;
  bit          stray_rv = 1'b0;
  int          n_reads  = 0;

  function automatic logic [31:0] init_val(input logic [29:0] wa);
    return {wa[15:0], ~wa[15:0]} ^ 32'h5A5A_3C3C;
  endfunction

  function automatic logic [31:0] rd_arch(input logic [29:0] wa);
    return arch.exists(wa) ? arch[wa] : init_val(wa);
  endfunction

  function automatic logic [31:0] rd_phys(input logic [29:0] wa);
    return phys.exists(wa) ? phys[wa] : init_val(wa);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic record_accept(input logic we, input logic [31:0] addr, input logic [31:0] data);
    st_entry_t e;
    if (we) begin
      arch[addr[31:2]] = data;
      e.waddr = addr[31:2];
      e.data  = data;
      exp_wr.push_back(e);
    end else begin
      exp_rsp.push_back(rd_arch(addr[31:2]));
    end
  endtask

  // Called just after a posedge; returns just after the posedge following acceptance.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] data);
    bit acc = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = data;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        acc = 1'b1;
        break;
      end
    end
    check("req_accept_timeout", acc, 1);
    if (acc) record_accept(we, addr, data);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (buf_empty && !bus.mem_req && !rd_busy && exp_rsp.size() == 0 && exp_wr.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    check("drain_timeout", done, 1);
    @(posedge clk); #1;
  endtask

  // Memory environment: grant policy and read-data return.
  initial begin
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    forever begin
      @(posedge clk); #2;
      bus.mem_rvalid = 1'b0;
      if (stray_rv) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hBAD0_BAD0;
        stray_rv       = 1'b0;
      end else if (rd_busy) begin
        if (rd_wait == 0) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = rd_phys(rd_addr[31:2]);
          rd_busy        = 1'b0;
        end else begin
          rd_wait--;
        end
      end else if (gnt_mode == 0 && $urandom_range(0, 7) == 0) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = $urandom;
      end
      case (gnt_mode)
        1:       bus.mem_gnt = 1'b1;
        2:       bus.mem_gnt = 1'b0;
        default: bus.mem_gnt = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: responses, memory handshakes and request stability.
  logic        prev_hold = 1'b0;
  logic        prev_we;
  logic [31:0] prev_addr;
  logic [31:0] prev_wdata;
  st_entry_t   mon_e;

  always @(negedge clk) begin
    if (!reset) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("mem_hold_req",   bus.mem_req,   1);
        check("mem_hold_we",    bus.mem_we,    prev_we);
        check("mem_hold_addr",  bus.mem_addr,  prev_addr);
        check("mem_hold_wdata", bus.mem_wdata, prev_wdata);
      end
      if (bus.rsp_valid) begin
        if (exp_rsp.size() == 0) check("rsp_unexpected", bus.rsp_valid, 0);
        else check("rsp_rdata", bus.rsp_rdata, exp_rsp.pop_front());
      end
      if (bus.mem_req && bus.mem_gnt) begin
        check("mem_addr_align", bus.mem_addr[1:0], 0);
        mem_log.push_back({bus.mem_we, bus.mem_addr});
        if (bus.mem_we) begin
          if (exp_wr.size() == 0) begin
            check("wr_unexpected", bus.mem_we, 0);
          end else begin
            mon_e = exp_wr.pop_front();
            check("wr_addr", bus.mem_addr, {mon_e.waddr, 2'b00});
            check("wr_data", bus.mem_wdata, mon_e.data);
          end
          phys[bus.mem_addr[31:2]] = bus.mem_wdata;
        end else begin
          n_reads++;
          rd_busy = 1'b1;
          rd_addr = bus.mem_addr;
          rd_wait = (lat_cfg >= 0) ? lat_cfg : int'($urandom_range(0, 4));
        end
      end
      prev_hold  = bus.mem_req && !bus.mem_gnt;
      prev_we    = bus.mem_we;
      prev_addr  = bus.mem_addr;
      prev_wdata = bus.mem_wdata;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    bit seen;
    reset         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    phys[30'h80]  = 32'hDEAD_BEEF;
    arch          = phys;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_req",   bus.mem_req,   0);
    check("rst_mem_we",    bus.mem_we,    0);
    check("rst_mem_addr",  bus.mem_addr,  0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_rdata", bus.rsp_rdata, 0);
    check("rst_buf_empty", buf_empty,     1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Single store drains; buf_empty back one cycle after grant
    gnt_mode = 1;
    do_req(1'b1, 32'h40, 32'h1111_1111);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.mem_req && bus.mem_gnt) begin seen = 1'b1; break; end
    end
    check("t1_store_issued", seen, 1);
    check("t1_mem_addr",  bus.mem_addr,  32'h40);
    check("t1_mem_wdata", bus.mem_wdata, 32'h1111_1111);
    @(negedge clk);
    check("t1_buf_empty", buf_empty, 1);
    wait_idle();

    // Fill to DEPTH, fifth store refused, drain in order
    gnt_mode = 2;
    mem_log.delete();
    for (int i = 0; i < 4; i++) do_req(1'b1, 32'(4 * i), 32'h100 + 32'(i));
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 32'h10;
    bus.req_wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check("t2_full_ready", bus.req_ready, 0);
    check("t2_buf_empty",  buf_empty,     0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    gnt_mode = 1;
    wait_idle();
    check("t2_drain_count", mem_log.size(), 4);
    if (mem_log.size() == 4)
      for (int i = 0; i < 4; i++) check("t2_drain_order", mem_log[i], {1'b1, 32'(4 * i)});

    // Forwarding from the youngest entry, low address bits ignored
    gnt_mode = 2;
    n0 = n_reads;
    do_req(1'b1, 32'h20, 32'hAAAA_0000);
    do_req(1'b1, 32'h22, 32'hBBBB_0000);
    do_req(1'b0, 32'h20, 32'h0);
    @(negedge clk);
    check("t3_rsp_valid", bus.rsp_valid, 1);
    check("t3_rsp_rdata", bus.rsp_rdata, 32'hBBBB_0000);
    gnt_mode = 1;
    wait_idle();
    check("t3_no_mem_read", n_reads - n0, 0);

    // Load miss overtakes a buffered store
    lat_cfg = 3;
    mem_log.delete();
    do_req(1'b1, 32'h100, 32'h1234_5678);
    do_req(1'b0, 32'h200, 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.mem_rvalid && rd_addr == 32'h200) begin seen = 1'b1; break; end
    end
    check("t4_rvalid_seen", seen, 1);
    @(negedge clk);
    check("t4_rsp_valid", bus.rsp_valid, 1);
    check("t4_rsp_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
    wait_idle();
    check("t4_mem_ops", mem_log.size(), 2);
    if (mem_log.size() == 2) begin
      check("t4_first_load",   mem_log[0], {1'b0, 32'h200});
      check("t4_second_store", mem_log[1], {1'b1, 32'h100});
    end

    // Reset during LD_WAIT with two buffered stores
    lat_cfg = 20;
    do_req(1'b0, 32'h300, 32'h0);
    do_req(1'b1, 32'h304, 32'h0000_0001);
    do_req(1'b1, 32'h308, 32'h0000_0002);
    @(posedge clk); #1;
    check("t5_pre_empty", buf_empty, 0);
    reset = 1'b0;
    exp_wr.delete();
    exp_rsp.delete();
    rd_busy = 1'b0;
    arch    = phys;
    #1;
    check("t5_mem_req",   bus.mem_req,   0);
    check("t5_buf_empty", buf_empty,     1);
    check("t5_rsp_valid", bus.rsp_valid, 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    stray_rv = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_no_rsp", bus.rsp_valid, 0);
    end
    @(posedge clk); #1;
    lat_cfg = -1;

    // Push and pop in the same cycle at count 3, then wrap-around order
    gnt_mode = 2;
    do_req(1'b1, 32'h500, 32'h5000_0000);
    do_req(1'b1, 32'h504, 32'h5000_0004);
    do_req(1'b1, 32'h508, 32'h5000_0008);
    gnt_mode      = 1;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 32'h50C;
    bus.req_wdata = 32'h5000_000C;
    @(negedge clk);
    check("t6_pushpop_ready", bus.req_ready, 1);
    if (bus.req_ready) record_accept(1'b1, 32'h50C, 32'h5000_000C);
    @(posedge clk); #1;
    gnt_mode      = 2;
    bus.req_addr  = 32'h510;
    bus.req_wdata = 32'h5000_0010;
    @(negedge clk);
    check("t6_count3_ready", bus.req_ready, 1);
    if (bus.req_ready) record_accept(1'b1, 32'h510, 32'h5000_0010);
    @(posedge clk); #1;
    bus.req_addr  = 32'h514;
    @(negedge clk);
    check("t6_full_ready", bus.req_ready, 0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    gnt_mode = 1;
    wait_idle();
    gnt_mode = 0;
    mem_log.delete();
    for (int i = 0; i < 10; i++) do_req(1'b1, 32'h600 + 32'(4 * i), $urandom);
    wait_idle();
    check("t6_wrap_count", mem_log.size(), 10);
    if (mem_log.size() == 10)
      for (int i = 0; i < 10; i++) check("t6_wrap_order", mem_log[i], {1'b1, 32'h600 + 32'(4 * i)});

    // Randomized mix over a small address pool to exercise hits and misses
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      a = 32'h800 + (32'($urandom_range(0, 7)) << 2) + 32'($urandom_range(0, 3));
      do_req(1'($urandom_range(0, 1)), a, $urandom);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    wait_idle();
    check("final_wr_queue",  exp_wr.size(),  0);
    check("final_rsp_queue", exp_rsp.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_write_buffer.md
Name: lsu_write_buffer

Overview:
- Load/store unit between the core's data-side outputs (MemWrite, DataAdr/ALUResult, WriteData) and the data memory port; supplies load data back to the core.
- Buffers stores in a FIFO and drains them to memory in the background.
- Forwards load data from buffered stores when the word address matches; otherwise issues the load to memory ahead of pending stores.
- Memory side uses a req/gnt/rvalid handshake with variable latency.

Parameters:
- DEPTH, 4, number of store-buffer entries (power of 2, at least 2).
- DW, 32, data width.
- AW, 32, address width.

Ports:
- clk, in, 1, clock.
- reset, in, 1, asynchronous, active-low reset.
- req_valid, in, 1, core request present.
- req_we, in, 1, 1 = store, 0 = load.
- req_addr, in, AW, byte address. Bits [1:0] are ignored (word access only).
- req_wdata, in, DW, store data.
- req_ready, out, 1, request accepted this cycle when req_valid and req_ready are both 1.
- rsp_valid, out, 1, load data valid (one-cycle pulse).
- rsp_rdata, out, DW, load data.
- mem_req, out, 1, memory request.
- mem_we, out, 1, memory write.
- mem_addr, out, AW, word-aligned address; bits [1:0] are always 0.
- mem_wdata, out, DW, memory write data.
- mem_gnt, in, 1, request accepted by memory.
- mem_rvalid, in, 1, memory read data valid.
- mem_rdata, in, DW, memory read data.
- buf_empty, out, 1, store buffer holds no entries and no store is in flight.

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO pointers and count go to 0; FSM goes to IDLE.
  - Outputs: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_rdata=0, buf_empty=1.
  - Buffered stores are discarded; an in-flight memory request is abandoned and mem_req drops immediately.
- FSM states: IDLE, ST_REQ, LD_REQ, LD_WAIT.
- Store acceptance:
  - req_ready=1 for a store iff count<DEPTH, in any FSM state.
  - An accepted store is enqueued with {addr[AW-1:2], wdata}.
  - A full buffer does not accept a store even if a pop occurs in the same cycle.
- Load forwarding (hit):
  - Compare addr[AW-1:2] against all valid entries, including the head entry while it is being drained.
  - On a hit, req_ready=1 unless the FSM is in LD_REQ or LD_WAIT.
  - The youngest matching entry supplies the data; memory is not accessed.
  - rsp_valid=1 and rsp_rdata are registered on the cycle after acceptance.
- Load miss:
  - Accepted only in IDLE.
  - Next cycle: LD_REQ with mem_req=1, mem_we=0, mem_addr latched.
  - mem_gnt: go to LD_WAIT and drop mem_req.
  - mem_rvalid in LD_WAIT: capture mem_rdata; rsp_valid=1 on the following cycle; go to IDLE.
- Load-miss priority: a miss in IDLE takes the memory port before any pending store drain. This reordering is legal only because a miss has no address match in the buffer.
- Drain:
  - In IDLE, with the buffer non-empty and no miss accepted this cycle, go to ST_REQ presenting the head entry.
  - mem_gnt in ST_REQ pops the head; the FSM returns to IDLE, or re-enters ST_REQ back-to-back if entries remain and no load miss is pending.
- Request stability: while mem_req=1, mem_addr, mem_we and mem_wdata are held stable until mem_gnt.
- Only one load is outstanding at a time. Every load produces exactly one rsp_valid pulse.
- Simultaneous enqueue and pop (count<DEPTH): count is unchanged and both pointers advance. Pointers wrap modulo DEPTH.
- buf_empty = (count==0) && state != ST_REQ.
- mem_rvalid outside LD_WAIT is ignored. mem_gnt while mem_req=0 is ignored.

Decomposition:
- Shared package xrisc_pkg holds:
  - the FSM state enum lsu_state_t;
  - the store-entry struct st_entry_t (word address, data);
  - the constant WORD_OFFSET_BITS=2.
- Sub-module sync_fifo holds the store FIFO: parameterised DEPTH/width, push, pop, full, empty, count, and exposes all entries for the match logic.
- Forwarding compare and the FSM stay in lsu_write_buffer.

Test Plan:
1. Reset, then store 0x11111111 to 0x40 with mem_gnt held 1 -> ST_REQ on the next cycle with mem_addr=0x40, mem_wdata=0x11111111; buf_empty returns to 1 one cycle after gnt.
2. mem_gnt=0, four stores to 0x0, 0x4, 0x8, 0xC -> req_ready=0 on a fifth store; releasing gnt drains the stores in order 0x0, 0x4, 0x8, 0xC.
3. mem_gnt=0, store 0xAAAA0000 to 0x20, then 0xBBBB0000 to 0x22, then load 0x20 -> rsp_valid one cycle later with rsp_rdata=0xBBBB0000 (youngest entry, bits [1:0] ignored); no load appears on the memory side.
4. Buffer holds a store to 0x100; load miss to 0x200 with gnt=1 and rvalid 3 cycles later with 0xDEADBEEF -> the load is issued before the store drain; rsp_rdata=0xDEADBEEF one cycle after rvalid; the store to 0x100 drains afterwards.
5. Assert reset in LD_WAIT with 2 entries buffered -> mem_req=0, buf_empty=1, no rsp_valid; a late mem_rvalid after reset release is ignored.
6. Buffer at count=3 with a pop and a push in the same cycle -> count stays 3; wrap-around over 10 pushes preserves FIFO order on mem_addr.
